// File: rtl/inst_defs_pkg.sv
// ============================================================================
// Module      : inst_defs_pkg
// Description : Shared instruction-decode constants (major opcodes, funct7
//               selectors, M-extension funct3 codes) and the multiply/divide
//               unit state encoding.
// Revision    : 1.0 - add M-extension funct3 codes and muldiv state enum
// ============================================================================
`default_nettype none

package inst_defs_pkg;

  // Major opcodes
  localparam logic [6:0] OPCODE_OP      = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM  = 7'b0010011;

  // funct7 selectors within OPCODE_OP
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

  // M-extension funct3: bit 2 splits multiply from divide
  localparam logic [2:0] FUNCT3_MUL     = 3'b000;
  localparam logic [2:0] FUNCT3_MULH    = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU  = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU   = 3'b011;
  localparam logic [2:0] FUNCT3_DIV     = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU    = 3'b101;
  localparam logic [2:0] FUNCT3_REM     = 3'b110;
  localparam logic [2:0] FUNCT3_REMU    = 3'b111;

  // Multiply/divide unit control states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_t;

endpackage

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module      : div_iter
// Description : Restoring radix-2 divider. One setup cycle (start), XLEN
//               iteration cycles, one sign-fixup cycle with done high.
//               Divide-by-zero and signed overflow finish in the start cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int ITW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            running;
  logic            fixup;
  logic [ITW-1:0]  iter;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  assign a_neg    = is_signed & dividend[XLEN-1];
  assign b_neg    = is_signed & divisor[XLEN-1];
  assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);

  // Partial remainder shifted left with the next dividend bit; the true
  // difference is below dvs whenever it fits, so XLEN bits suffice for it.
  assign shifted  = {rem, quo[XLEN-1]};
  assign fits     = (shifted >= {1'b0, dvs});
  assign diff     = shifted[XLEN-1:0] - dvs;

  // Setup, iteration and fixup sequencing
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      running <= 1'b0;
      fixup   <= 1'b0;
      iter    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start && !div_zero && !overflow) begin
      running <= 1'b1;
      fixup   <= 1'b0;
      iter    <= '0;
      quo     <= a_mag;
      rem     <= '0;
      dvs     <= b_mag;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
    end else if (running) begin
      quo  <= {quo[XLEN-2:0], fits};
      rem  <= fits ? diff : shifted[XLEN-1:0];
      iter <= iter + 1'b1;
      if (iter == ITW'(XLEN-1)) begin
        running <= 1'b0;
        fixup   <= 1'b1;
      end
    end else if (fixup) begin
      fixup <= 1'b0;
    end
  end

  // Result selection: special cases answer immediately, otherwise sign fixup
  always_comb begin
    done      = fixup;
    quotient  = neg_q ? (~quo + 1'b1) : quo;
    remainder = neg_r ? (~rem + 1'b1) : rem;
    if (start && div_zero) begin
      done      = 1'b1;
      quotient  = '1;
      remainder = dividend;
    end else if (start && overflow) begin
      done      = 1'b1;
      quotient  = dividend;
      remainder = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Single-outstanding RV M-extension multiply/divide unit with
//               valid/ready handshakes, a pipelined multiplier and an
//               iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  import inst_defs_pkg::*;

  localparam int CW = $clog2(XLEN + 3);

  muldiv_state_t     state;
  muldiv_state_t     state_next;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;

  logic              accept;
  logic              mul_last;
  logic              div_start;
  logic              div_done;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;

  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_sel;
  logic [XLEN-1:0]   mul_out;

  assign in_ready  = (state == MD_IDLE);
  assign busy      = (state != MD_IDLE);
  assign out_valid = (state == MD_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign mul_last  = (state == MD_MUL) && (cnt == CW'(MUL_STAGES - 1));
  assign div_start = (state == MD_DIV) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush overrides acceptance and completion
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (in_valid) state_next = op[2] ? MD_DIV : MD_MUL;
      MD_MUL:  if (mul_last) state_next = MD_DONE;
      MD_DIV:  if (div_done) state_next = MD_DONE;
      MD_DONE: if (out_ready) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  // Operand latches and cycle counter; operands are frozen while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_q <= op[1:0];
      a_q  <= a;
      b_q  <= b;
      cnt  <= '0;
    end else if (state == MD_MUL || state == MD_DIV) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Multiply operand extension: MULHU is unsigned x unsigned, MULHSU signed x
  // unsigned, MUL/MULH signed x signed.
  assign a_signed = (op_q != FUNCT3_MULHU[1:0]);
  assign b_signed = !op_q[1];
  assign a_ext    = {{XLEN{a_signed & a_q[XLEN-1]}}, a_q};
  assign b_ext    = {{XLEN{b_signed & b_q[XLEN-1]}}, b_q};
  assign prod     = a_ext * b_ext;
  assign mul_sel  = (op_q == FUNCT3_MUL[1:0]) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // The result register is the final multiply stage; earlier stages live here
  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_out = mul_sel;
    end else begin : g_mul_pipe
      logic [XLEN-1:0] stage_q [MUL_STAGES-1];

      // Product pipeline advancing every cycle behind the latched operands
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= mul_sel;
          for (int i = 1; i < MUL_STAGES - 1; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign mul_out = stage_q[MUL_STAGES-2];
    end
  endgenerate

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .abort     (flush),
    .start     (div_start),
    .is_signed (!op_q[0]),
    .dividend  (a_q),
    .divisor   (b_q),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Result capture on completion; held unchanged through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (!flush) begin
      if (mul_last)                            result <= mul_out;
      else if (state == MD_DIV && div_done)    result <= op_q[1] ? div_rem : div_quo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit (XLEN=32, MUL_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  import inst_defs_pkg::*;

  localparam int XLEN = 32;
  localparam int MS   = 2;
  localparam int LDIV = XLEN + 2;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] exp;
    int              lat;
    int              acc;
    string           name;
  } item_t;

  item_t sb[$];
  int    vectors = 0;
  int    errors  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: latency on rise, stability while stalled, compare on handshake
  logic            held_valid = 1'b0;
  logic [XLEN-1:0] held_result;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        check("in_ready_low_in_done", {63'd0, in_ready}, 64'd0);
        if (!held_valid) begin
          if (sb.size() == 0) check("unexpected_output", 64'd1, 64'd0);
          else check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end else begin
          check("result_stable", {32'd0, result}, {32'd0, held_result});
        end
        held_result = result;
        if (out_ready && sb.size() > 0) begin
          item_t it;
          it = sb.pop_front();
          check(it.name, {32'd0, result}, {32'd0, it.exp});
        end
      end
      held_valid = out_valid && !out_ready;
    end
  end

  // Drive one request once the unit is ready; returns on the negedge after accept
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                       input logic [XLEN-1:0] exp, input int lat, input string nm, input bit push);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check({nm, "_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    op = f3;
    a  = va;
    b  = vb;
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
    if (push) begin
      item_t it;
      it.exp  = exp;
      it.lat  = lat;
      it.acc  = cyc;
      it.name = nm;
      sb.push_back(it);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb.size() != 0 || !in_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_result",    {32'd0, result},    64'd0);
    reset = 1'b0;

    // Multiplies
    issue(FUNCT3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MS, "mul_7_m3",      1'b1);
    issue(FUNCT3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MS, "mulhu_ff",      1'b1);
    issue(FUNCT3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MS, "mulh_m1",       1'b1);
    issue(FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MS, "mulhsu_m1",     1'b1);
    issue(FUNCT3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, MS, "mul_shift",     1'b1);
    issue(FUNCT3_MULHU,  32'h12345678, 32'h00000010, 32'h00000001, MS, "mulhu_shift",   1'b1);

    // Divides
    issue(FUNCT3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LDIV, "div_m7_2",   1'b1);
    issue(FUNCT3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LDIV, "rem_m7_2",   1'b1);
    issue(FUNCT3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LDIV, "div_7_m2",   1'b1);
    issue(FUNCT3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, LDIV, "rem_7_m2",   1'b1);
    issue(FUNCT3_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, LDIV, "rem_m7_m2",  1'b1);
    issue(FUNCT3_DIVU,   32'd100,      32'd7,        32'd14,       LDIV, "divu_100_7", 1'b1);
    issue(FUNCT3_REMU,   32'd100,      32'd7,        32'd2,        LDIV, "remu_100_7", 1'b1);
    issue(FUNCT3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        LDIV, "divu_big",   1'b1);
    issue(FUNCT3_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, LDIV, "remu_big",   1'b1);
    issue(FUNCT3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, LDIV, "divu_by1",   1'b1);

    // Special cases
    issue(FUNCT3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_by0",      1'b1);
    issue(FUNCT3_REMU,   32'd5,        32'd0,        32'd5,        1, "remu_by0",      1'b1);
    issue(FUNCT3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf",       1'b1);
    issue(FUNCT3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem_ovf",       1'b1);
    drain();

    // Consumer stall: result held, no accept until after the handshake
    issue(FUNCT3_MUL, 32'd6, 32'd7, 32'd42, MS, "mul_stall", 1'b1);
    out_ready = 1'b0;
    begin
      int waited = 0;
      while (!out_valid && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check("stall_valid_seen", {63'd0, out_valid}, 64'd1);
    end
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = FUNCT3_MUL;
    a         = 32'd2;
    b         = 32'd5;
    @(negedge clk);
    check("no_same_cycle_accept", {62'd0, in_ready, busy}, 64'd2);
    @(negedge clk);
    in_valid = 1'b0;
    begin
      item_t it;
      it.exp  = 32'd10;
      it.lat  = MS;
      it.acc  = cyc;
      it.name = "mul_after_stall";
      sb.push_back(it);
    end
    drain();

    // Flush mid-divide: back to idle, nothing produced
    issue(FUNCT3_DIVU, 32'd1000, 32'd3, 32'd0, 0, "divu_flushed", 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {61'd0, in_ready, busy, out_valid}, 64'd4);
    repeat (40) @(negedge clk);

    // Reset mid-divide: back to idle, nothing produced
    issue(FUNCT3_DIVU, 32'd1000, 32'd3, 32'd0, 0, "divu_reset", 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_idle", {61'd0, in_ready, busy, out_valid}, 64'd4);
    repeat (40) @(negedge clk);

    issue(FUNCT3_MUL, 32'd3, 32'd4, 32'd12, MS, "mul_3x4", 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
